// File: rtl/alu_sequencer_if.sv
// Instruction handshake plus operand/result bus between the sequencer and the external ALU.
// master = instruction source and ALU side, slave = sequencer.
interface alu_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] instr;
    logic [2:0]  OpCode;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] x3;

    modport master (
        output in_valid, instr, x3,
        input  in_ready, OpCode, x1, x2
    );

    modport slave (
        input  in_valid, instr, x3,
        output in_ready, OpCode, x1, x2
    );
endinterface

// File: rtl/alu_sequencer.sv
// Serial instruction sequencer: issues register operands to an external ALU and writes its
// registered result back into an 8 x 32 register file. Load-immediates retire in one cycle.
module alu_sequencer (
    input  logic                  clk,
    input  logic                  rst,
    alu_sequencer_if.slave        bus,
    output logic                  wb_valid,
    output logic                  illegal,
    input  logic [2:0]            dbg_addr,
    output logic [31:0]           dbg_data,
    output logic [15:0]           retired
);

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e      state_q, state_d;
    logic [31:0] rf_q [8];
    logic [2:0]  opcode_q;
    logic [31:0] x1_q;
    logic [31:0] x2_q;
    logic [2:0]  rd_q;
    logic        wb_valid_q;
    logic        illegal_q;
    logic [15:0] retired_q;
    logic        in_ready;

    logic        is_li;
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        op_legal;
    logic        accept;
    logic        issue;

    assign is_li    = bus.instr[19];
    assign op       = bus.instr[18:16];
    assign rd       = bus.instr[15:13];
    assign rs1      = bus.instr[12:10];
    assign rs2      = bus.instr[9:7];
    assign op_legal = (op != 3'b010) && (op != 3'b111);
    assign accept   = bus.in_valid && in_ready;
    assign issue    = accept && !is_li && op_legal;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = issue ? StExec : StIdle;
            StExec:  state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = 1'b0;
        if (state_q == StIdle) begin
            in_ready = 1'b1;
        end
    end

    // Datapath: rf[0] is never written, so it reads back as zero without a read-side mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 32'h0;
            end
            opcode_q   <= 3'b000;
            x1_q       <= 32'h0;
            x2_q       <= 32'h0;
            rd_q       <= 3'd0;
            wb_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            retired_q  <= 16'h0;
        end else begin
            wb_valid_q <= (accept && is_li) || (state_q == StExec);
            illegal_q  <= accept && !is_li && !op_legal;

            if (issue) begin
                opcode_q <= op;
                x1_q     <= rf_q[rs1];
                x2_q     <= rf_q[rs2];
                rd_q     <= rd;
            end

            if (accept && is_li) begin
                if (rd != 3'd0) begin
                    rf_q[rd] <= {19'b0, bus.instr[12:0]};
                end
                retired_q <= retired_q + 16'd1;
            end

            // ALU result was captured at the end of EXEC and is stable throughout WB.
            if (state_q == StWb) begin
                if (rd_q != 3'd0) begin
                    rf_q[rd_q] <= bus.x3;
                end
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.OpCode   = opcode_q;
    assign bus.x1       = x1_q;
    assign bus.x2       = x2_q;
    assign wb_valid     = wb_valid_q;
    assign illegal      = illegal_q;
    assign retired      = retired_q;
    assign dbg_data     = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed and random instructions against an architectural
// register-file model, with a registered ALU model driving x3.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid;
    logic        illegal;
    logic [2:0]  dbg_addr = 3'd0;
    logic [31:0] dbg_data;
    logic [15:0] retired;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .wb_valid (wb_valid),
        .illegal  (illegal),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Architectural state expected after each instruction completes
    logic [31:0] ref_rf [8];
    logic [15:0] ref_retired;
    logic [2:0]  ref_op;
    logic [31:0] ref_x1;
    logic [31:0] ref_x2;

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b011:  return a & b;
            3'b100:  return a | b;
            3'b101:  return a ^ b;
            3'b110:  return a << b[4:0];
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // External ALU: result registered on posedge
    always_ff @(posedge clk) begin
        bus.x3 <= alu_ref(bus.OpCode, bus.x1, bus.x2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_rf[i] = 32'h0;
        ref_retired = 16'h0;
        ref_op = 3'b000;
        ref_x1 = 32'h0;
        ref_x2 = 32'h0;
    endtask

    // Only called with in_valid low and the sequencer idle, so the extra #1 steps are harmless.
    task automatic check_rf(input string tag);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            chk($sformatf("%s_rf%0d", tag, r), dbg_data, ref_rf[r]);
        end
        @(negedge clk);
    endtask

    // Offer one instruction, follow it to completion and check every visible effect.
    task automatic issue(input logic [19:0] ins);
        int n;
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [31:0] res;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.instr    = 20'($urandom);
        op = ins[18:16];
        rd = ins[15:13];
        if (ins[19]) begin
            if (rd != 3'd0) ref_rf[rd] = {19'b0, ins[12:0]};
            ref_retired++;
            chk("li_wb", {31'b0, wb_valid}, 32'd1);
            chk("li_ill", {31'b0, illegal}, 32'd0);
            chk("li_ready", {31'b0, bus.in_ready}, 32'd1);
            chk("li_retired", {16'b0, retired}, {16'b0, ref_retired});
            chk("li_opcode", {29'b0, bus.OpCode}, {29'b0, ref_op});
            chk("li_x1", bus.x1, ref_x1);
            chk("li_x2", bus.x2, ref_x2);
        end else if (op == 3'b010 || op == 3'b111) begin
            chk("ill_pulse", {31'b0, illegal}, 32'd1);
            chk("ill_wb", {31'b0, wb_valid}, 32'd0);
            chk("ill_ready", {31'b0, bus.in_ready}, 32'd1);
            chk("ill_opcode", {29'b0, bus.OpCode}, {29'b0, ref_op});
            chk("ill_x1", bus.x1, ref_x1);
            chk("ill_retired", {16'b0, retired}, {16'b0, ref_retired});
            @(negedge clk);
            chk("ill_once", {31'b0, illegal}, 32'd0);
        end else begin
            ref_op = op;
            ref_x1 = ref_rf[ins[12:10]];
            ref_x2 = ref_rf[ins[9:7]];
            res = alu_ref(op, ref_x1, ref_x2);
            chk("exec_opcode", {29'b0, bus.OpCode}, {29'b0, ref_op});
            chk("exec_x1", bus.x1, ref_x1);
            chk("exec_x2", bus.x2, ref_x2);
            chk("exec_ready", {31'b0, bus.in_ready}, 32'd0);
            chk("exec_wb", {31'b0, wb_valid}, 32'd0);
            @(negedge clk);
            chk("wb_pulse", {31'b0, wb_valid}, 32'd1);
            chk("wb_ready", {31'b0, bus.in_ready}, 32'd0);
            chk("wb_x1_hold", bus.x1, ref_x1);
            @(negedge clk);
            if (rd != 3'd0) ref_rf[rd] = res;
            ref_retired++;
            chk("done_wb", {31'b0, wb_valid}, 32'd0);
            chk("done_ready", {31'b0, bus.in_ready}, 32'd1);
            chk("done_retired", {16'b0, retired}, {16'b0, ref_retired});
        end
    endtask

    function automatic logic [19:0] alu_instr(input logic [2:0] op, input logic [2:0] rd,
                                              input logic [2:0] rs1, input logic [2:0] rs2);
        return {1'b0, op, rd, rs1, rs2, 7'($urandom)};
    endfunction

    function automatic logic [19:0] li_instr(input logic [2:0] rd, input logic [12:0] imm);
        return {1'b1, 3'($urandom), rd, imm};
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wb_count;
        logic [2:0] ops [6];
        ops = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110};
        bus.in_valid = 1'b0;
        bus.instr    = 20'h0;
        model_reset();

        // Reset state
        @(negedge clk);
        chk("rst_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_wb", {31'b0, wb_valid}, 32'd0);
        chk("rst_ill", {31'b0, illegal}, 32'd0);
        chk("rst_retired", {16'b0, retired}, 32'd0);
        chk("rst_opcode", {29'b0, bus.OpCode}, 32'd0);
        chk("rst_x1", bus.x1, 32'd0);
        chk("rst_x2", bus.x2, 32'd0);
        rst = 1'b0;
        check_rf("rst");

        // Load-and-add
        issue(li_instr(3'd1, 13'd5));
        issue(li_instr(3'd2, 13'd7));
        issue(alu_instr(3'b000, 3'd3, 3'd1, 3'd2));
        chk("la_rf3_model", ref_rf[3], 32'h0000_000C);
        chk("la_retired", {16'b0, retired}, 32'd3);
        check_rf("la");

        // in_valid held high: accepts every third cycle, r5 += r1 applied exactly twice
        wb_count = 0;
        bus.in_valid = 1'b1;
        bus.instr    = alu_instr(3'b000, 3'd5, 3'd5, 3'd1);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("hs_ready%0d", k), {31'b0, bus.in_ready}, (k % 3 == 0) ? 32'd1 : 32'd0);
            if (wb_valid) wb_count++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (wb_valid) wb_count++;
        chk("hs_wb_count", wb_count, 32'd2);
        ref_rf[5] = ref_rf[5] + 2 * ref_rf[1];
        ref_retired += 2;
        ref_op = 3'b000;
        ref_x1 = ref_rf[5] - ref_rf[1];
        ref_x2 = ref_rf[1];
        chk("hs_retired", {16'b0, retired}, {16'b0, ref_retired});
        check_rf("hs");

        // Illegal ops and r0 writes
        issue(alu_instr(3'b010, 3'd3, 3'd1, 3'd2));
        issue(alu_instr(3'b111, 3'd6, 3'd2, 3'd3));
        issue(alu_instr(3'b100, 3'd0, 3'd1, 3'd2));
        issue(li_instr(3'd0, 13'h1ABC));
        check_rf("r0");

        // Random mix
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0, 1: issue(li_instr(3'($urandom), 13'($urandom)));
                2:    issue(alu_instr(($urandom_range(0, 1) == 0) ? 3'b010 : 3'b111,
                                      3'($urandom), 3'($urandom), 3'($urandom)));
                default: issue(alu_instr(ops[$urandom_range(0, 5)],
                                         3'($urandom), 3'($urandom), 3'($urandom)));
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        check_rf("rand");

        // Reset during EXEC aborts the instruction
        issue(li_instr(3'd4, 13'd123));
        bus.in_valid = 1'b1;
        bus.instr    = alu_instr(3'b101, 3'd4, 3'd4, 3'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("mid_exec", {31'b0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_async_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("mid_async_retired", {16'b0, retired}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mid_wb", {31'b0, wb_valid}, 32'd0);
        chk("mid_retired", {16'b0, retired}, 32'd0);
        chk("mid_ready", {31'b0, bus.in_ready}, 32'd1);
        check_rf("mid");

        // Retired counter wrap
        bus.in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            bus.instr = {1'b1, 3'b000, 3'd6, 13'(i)};
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        ref_retired = 16'hFFFF;
        ref_rf[6] = {19'b0, 13'(65534)};
        @(negedge clk);
        chk("wrap_ffff", {16'b0, retired}, 32'h0000_FFFF);
        issue(li_instr(3'd7, 13'd42));
        chk("wrap_zero", {16'b0, retired}, 32'h0000_0000);
        check_rf("wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameters: none; register file fixed at 8 x 32 bits, instruction word 20 bits.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  instruction offered.
REQ-005 in_ready  output  1  sequencer can accept an instruction this cycle.
REQ-006 instr  input  20  [19] li, [18:16] op, [15:13] rd, [12:10] rs1, [9:7] rs2, [6:0] unused; li=1: imm = instr[12:0].
REQ-007 OpCode  output  3  to ALU OpCode, registered.
REQ-008 x1  output  32  to ALU x1, registered.
REQ-009 x2  output  32  to ALU x2, registered.
REQ-010 x3  input  32  ALU result, registered inside the ALU on posedge clk.
REQ-011 wb_valid  output  1  one-cycle pulse when rd is written.
REQ-012 illegal  output  1  one-cycle pulse for an unsupported op.
REQ-013 dbg_addr  input  3  debug read index; dbg_data  output  32  combinational rf[dbg_addr].
REQ-014 retired  output  16  count of completed writebacks.

Function
REQ-015 States: IDLE, EXEC, WB; in_ready = 1 only in IDLE.
REQ-016 Accept occurs on a posedge with in_valid=1 and in_ready=1; instr is ignored otherwise.
REQ-017 Accept, li=0, op in {000,001,011,100,101,110}: OpCode<=op, x1<=rf[rs1], x2<=rf[rs2], rd latched, IDLE->EXEC.
REQ-018 EXEC lasts exactly one cycle (ALU captures x3 at its end); EXEC->WB unconditionally.
REQ-019 WB: at the end of the cycle, rf[rd]<=x3, wb_valid=1 during WB, retired+=1, WB->IDLE.
REQ-020 Latency: accept at edge N -> rf[rd] updated at edge N+2; next accept possible at edge N+3.
REQ-021 Accept, li=1: rf[rd]<={19'b0, instr[12:0]} at the accepting edge, wb_valid pulses the following cycle, retired+=1, state stays IDLE, OpCode/x1/x2 unchanged.
REQ-022 Accept, li=0, op in {010,111}: no ALU issue, no writeback; illegal pulses the following cycle; state stays IDLE; OpCode/x1/x2 unchanged.
REQ-023 rf[0] reads as zero always; writes with rd=0 are discarded, but wb_valid and retired still update.
REQ-024 retired wraps from 16'hFFFF to 16'h0000.
REQ-025 Operands are read at the accept edge; since issue is serial, there is no forwarding and no hazard logic.
REQ-026 In EXEC/WB, OpCode/x1/x2 hold their issued values until the next issue.
REQ-027 Width rules: no sign or zero extension is applied to x3, which is written verbatim.

Reset
REQ-028 rst=1 immediately forces: state=IDLE, all rf entries=0, OpCode=3'b000, x1=x2=0, wb_valid=0, illegal=0, retired=0.
REQ-029 rst asserted in EXEC or WB aborts the instruction: no rf write and no retired increment.
REQ-030 First accept is possible on the first posedge after rst deasserts.

Verification
REQ-031 Load-and-add: li r1=5, li r2=7, then op=000 rd=3 rs1=1 rs2=2 -> rf[3]=32'h0000000C at accept+2, retired=3.
REQ-032 Handshake: in_valid held high across EXEC/WB -> in_ready=0 for 2 cycles; exactly one accept per 3 cycles; no duplicate writeback.
REQ-033 Illegal op: op=010 -> illegal pulses once, no wb_valid, no rf change, OpCode unchanged.
REQ-034 r0: op=100 rd=0 -> rf[0] still reads 0 via dbg_data, while wb_valid=1 and retired increments.
REQ-035 Reset mid-op: assert rst during EXEC of op=101 rd=4 -> rf[4]=0, retired=0, in_ready=1 after release.
REQ-036 Wrap: preload retired to 16'hFFFF via 65535 li ops, then one more -> retired=16'h0000.
